// File: rtl/led_pattern_pkg.sv
// rtl/led_pattern_pkg.sv - state encoding, special status codes and code decode for the LED blink-code driver
package led_pattern_pkg;

   typedef enum logic [2:0] {
      S_OFF   = 3'd0,
      S_SOLID = 3'd1,
      S_ON    = 3'd2,
      S_DARK  = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   localparam logic [3:0] CODE_OFF   = 4'd0;
   localparam logic [3:0] CODE_SOLID = 4'd15;

   // Entry state for a freshly applied code; pulse codes always start on their first pulse.
   function automatic state_t decode_code(input logic [3:0] c);
      if (c == CODE_OFF) begin
         return S_OFF;
      end else if (c == CODE_SOLID) begin
         return S_SOLID;
      end
      return S_ON;
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - prescaler producing a one-clock tick every TICK_DIV+1 clocks, with sync clear
module led_tick_gen #(
   parameter int TICK_DIV = 4999999
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   output logic o_tick,
   output logic o_tick_nxt
);

   localparam int CW = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
   localparam logic [CW-1:0] TERM = CW'(TICK_DIV);

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;

   always_comb begin
      w_cnt_nxt = r_cnt + CW'(1);
      if (i_clr || (r_cnt == TERM)) begin
         w_cnt_nxt = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
      end
   end

   // o_tick_nxt lets the parent register outputs that must line up with the next tick.
   assign o_tick     = (r_cnt == TERM);
   assign o_tick_nxt = (w_cnt_nxt == TERM);

endmodule

// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - status blink-code LED driver; LED_PWM_DIM_EN adds PWM brightness dimming
module led_pattern_sequencer
   import led_pattern_pkg::*;
#(
   parameter int TICK_DIV  = 4999999,
   parameter int ON_TICKS  = 2,
   parameter int OFF_TICKS = 3,
   parameter int GAP_TICKS = 10
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] code,
   input  logic       code_load,
`ifdef LED_PWM_DIM_EN
   input  logic [7:0] brightness,
`endif
   output logic       led,
   output logic       frame_done
);

   localparam int PH_MAX0 = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int PH_MAX  = (PH_MAX0 > GAP_TICKS) ? PH_MAX0 : GAP_TICKS;
   localparam int PW      = $clog2(PH_MAX + 1);
   localparam logic [PW-1:0] ON_LAST  = PW'(ON_TICKS - 1);
   localparam logic [PW-1:0] OFF_LAST = PW'(OFF_TICKS - 1);
   localparam logic [PW-1:0] GAP_LAST = PW'(GAP_TICKS - 1);

   state_t        r_state, w_state_nxt;
   logic [3:0]    r_pending, w_pending_nxt;
   logic [3:0]    r_active, w_active_nxt;
   logic [3:0]    r_pulse, w_pulse_nxt;
   logic [PW-1:0] r_phase, w_phase_nxt;
   logic          w_clr;
   logic          w_tick;
   logic          w_tick_nxt;
   logic          w_lit_nxt;
   logic          w_led_nxt;
   logic          w_done_nxt;
   logic          r_led;
   logic          r_frame_done;

   led_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk        (clk),
      .rst_n      (reset_n),
      .i_clr      (w_clr),
      .o_tick     (w_tick),
      .o_tick_nxt (w_tick_nxt)
   );

   assign w_pending_nxt = code_load ? code : r_pending;

   always_comb begin
      w_state_nxt  = r_state;
      w_active_nxt = r_active;
      w_pulse_nxt  = r_pulse;
      w_phase_nxt  = r_phase;
      w_clr        = 1'b0;
      unique case (r_state)
         S_OFF, S_SOLID: begin
            if (code_load) begin
               w_active_nxt = code;
               w_state_nxt  = decode_code(code);
               w_pulse_nxt  = 4'd1;
               w_phase_nxt  = '0;
               w_clr        = 1'b1;
            end
         end
         S_ON: begin
            if (w_tick) begin
               if (r_phase == ON_LAST) begin
                  w_phase_nxt = '0;
                  w_state_nxt = S_DARK;
               end else begin
                  w_phase_nxt = r_phase + PW'(1);
               end
            end
         end
         // Every pulse keeps its dark phase; the gap follows the last pulse's dark phase.
         S_DARK: begin
            if (w_tick) begin
               if (r_phase == OFF_LAST) begin
                  w_phase_nxt = '0;
                  if (r_pulse == r_active) begin
                     w_state_nxt = S_GAP;
                  end else begin
                     w_state_nxt = S_ON;
                     w_pulse_nxt = r_pulse + 4'd1;
                  end
               end else begin
                  w_phase_nxt = r_phase + PW'(1);
               end
            end
         end
         S_GAP: begin
            if (w_tick) begin
               if (r_phase == GAP_LAST) begin
                  w_phase_nxt  = '0;
                  w_active_nxt = w_pending_nxt;
                  w_state_nxt  = decode_code(w_pending_nxt);
                  w_pulse_nxt  = 4'd1;
               end else begin
                  w_phase_nxt = r_phase + PW'(1);
               end
            end
         end
         default: begin
            w_state_nxt = S_OFF;
            w_phase_nxt = '0;
            w_pulse_nxt = '0;
         end
      endcase
   end

   assign w_lit_nxt  = (w_state_nxt == S_SOLID) || (w_state_nxt == S_ON);
   // Asserted one clock early so the registered pulse covers the final gap clock itself.
   assign w_done_nxt = (w_state_nxt == S_GAP) && (w_phase_nxt == GAP_LAST) && w_tick_nxt;

`ifdef LED_PWM_DIM_EN
   logic [7:0] r_pwm;
   logic [7:0] w_pwm_nxt;

   assign w_pwm_nxt = r_pwm + 8'd1;
   assign w_led_nxt = w_lit_nxt && (w_pwm_nxt < brightness);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pwm <= 8'd0;
      end else begin
         r_pwm <= w_pwm_nxt;
      end
   end
`else
   assign w_led_nxt = w_lit_nxt;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_OFF;
         r_pending    <= 4'd0;
         r_active     <= 4'd0;
         r_pulse      <= 4'd0;
         r_phase      <= '0;
         r_led        <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_pending    <= w_pending_nxt;
         r_active     <= w_active_nxt;
         r_pulse      <= w_pulse_nxt;
         r_phase      <= w_phase_nxt;
         r_led        <= w_led_nxt;
         r_frame_done <= w_done_nxt;
      end
   end

   assign led        = r_led;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb/tb_led_pattern_sequencer.sv - scoreboard bench for led_pattern_sequencer (tick = 4 clocks)
module tb_led_pattern_sequencer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] code = 4'd0;
   logic       code_load = 1'b0;
   logic       led;
   logic       frame_done;
`ifdef LED_PWM_DIM_EN
   logic [7:0] brightness = 8'd0;
`endif

   int checks = 0;
   int errors = 0;
   logic [1:0] exp_q[$];
   logic [1:0] exp_v;
   logic [1:0] got_v;

   led_pattern_sequencer #(
      .TICK_DIV  (3),
      .ON_TICKS  (2),
      .OFF_TICKS (3),
      .GAP_TICKS (10)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .code       (code),
      .code_load  (code_load),
`ifdef LED_PWM_DIM_EN
      .brightness (brightness),
`endif
      .led        (led),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Expected {led, frame_done} per clock: 8 lit + 12 dark per pulse, 40 dark gap, done on the last gap clock.
   task automatic push(input logic l, input logic f, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({l, f});
   endtask

   task automatic push_frame(input int pulses);
      for (int p = 0; p < pulses; p++) begin
         push(1'b1, 1'b0, 8);
         push(1'b0, 1'b0, 12);
      end
      push(1'b0, 1'b0, 39);
      push(1'b0, 1'b1, 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      code_load = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      exp_q.delete();
   endtask

   // Consumes one clock; that clock's expectation (if any) is dropped since it precedes the load edge.
   task automatic load(input logic [3:0] c);
      @(negedge clk);
      if (exp_q.size() != 0) exp_q.delete(0);
      code = c;
      code_load = 1'b1;
      @(posedge clk);
      #1 code_load = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (led !== 1'b0) begin
         errors++;
         $display("FAIL reset_led got %b expected 0", led);
      end
      checks++;
      if (frame_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_frame_done got %b expected 0", frame_done);
      end
      do_reset();
      push(1'b0, 1'b0, 20);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         got_v = {led, frame_done};
         exp_v = exp_q.pop_front();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL reset_idle cycle %0d got %b expected %b", i, got_v, exp_v);
         end
      end
   endtask

   task automatic test_code3();
      do_reset();
      load(4'd3);
      push_frame(3);
      push_frame(3);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         got_v = {led, frame_done};
         exp_v = exp_q.pop_front();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL code3 cycle %0d led,frame_done got %b expected %b", i, got_v, exp_v);
         end
      end
   endtask

   task automatic test_solid();
      do_reset();
      load(4'd15);
      push(1'b1, 1'b0, 20);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         got_v = {led, frame_done};
         exp_v = exp_q.pop_front();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL solid_on cycle %0d got %b expected %b", i, got_v, exp_v);
         end
      end
      load(4'd0);
      push(1'b0, 1'b0, 20);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         got_v = {led, frame_done};
         exp_v = exp_q.pop_front();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL solid_off cycle %0d got %b expected %b", i, got_v, exp_v);
         end
      end
   endtask

   task automatic test_deferred_load();
      do_reset();
      load(4'd3);
      push_frame(3);
      push_frame(5);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         got_v = {led, frame_done};
         exp_v = exp_q.pop_front();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL deferred_pre cycle %0d got %b expected %b", i, got_v, exp_v);
         end
      end
      load(4'd5);
      for (int i = 31; i < 240; i++) begin
         @(negedge clk);
         got_v = {led, frame_done};
         exp_v = exp_q.pop_front();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL deferred_post cycle %0d got %b expected %b", i, got_v, exp_v);
         end
      end
   endtask

   task automatic test_load_at_frame_end();
      do_reset();
      load(4'd3);
      push_frame(3);
      push_frame(1);
      push_frame(1);
      for (int i = 0; i < 99; i++) begin
         @(negedge clk);
         got_v = {led, frame_done};
         exp_v = exp_q.pop_front();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL edge_pre cycle %0d got %b expected %b", i, got_v, exp_v);
         end
      end
      @(negedge clk);
      got_v = {led, frame_done};
      exp_v = exp_q.pop_front();
      checks++;
      if (got_v !== exp_v) begin
         errors++;
         $display("FAIL edge_done got %b expected %b", got_v, exp_v);
      end
      code = 4'd1;
      code_load = 1'b1;
      @(posedge clk);
      #1 code_load = 1'b0;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         got_v = {led, frame_done};
         exp_v = exp_q.pop_front();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL edge_post cycle %0d got %b expected %b", i, got_v, exp_v);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      load(4'd7);
      push_frame(7);
      for (int i = 0; i < 43; i++) begin
         @(negedge clk);
         got_v = {led, frame_done};
         exp_v = exp_q.pop_front();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL mid_pre cycle %0d got %b expected %b", i, got_v, exp_v);
         end
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({led, frame_done} !== 2'b00) begin
         errors++;
         $display("FAIL async_reset led,frame_done got %b expected 00", {led, frame_done});
      end
      exp_q.delete();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      push(1'b0, 1'b0, 50);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         got_v = {led, frame_done};
         exp_v = exp_q.pop_front();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL mid_idle cycle %0d got %b expected %b", i, got_v, exp_v);
         end
      end
      load(4'd1);
      push_frame(1);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         got_v = {led, frame_done};
         exp_v = exp_q.pop_front();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL mid_reload cycle %0d got %b expected %b", i, got_v, exp_v);
         end
      end
   endtask

`ifdef LED_PWM_DIM_EN
   task automatic test_pwm();
      int lit;
      int exp_cnt[$];
      do_reset();
      brightness = 8'd64;
      load(4'd15);
      exp_cnt.push_back(128);
      lit = 0;
      for (int i = 0; i < 512; i++) begin
         @(negedge clk);
         if (led === 1'b1) lit++;
      end
      checks++;
      if (lit !== exp_cnt.pop_front()) begin
         errors++;
         $display("FAIL pwm_64 lit clocks got %0d expected 128", lit);
      end
      brightness = 8'd0;
      exp_cnt.push_back(0);
      repeat (2) @(negedge clk);
      lit = 0;
      for (int i = 0; i < 512; i++) begin
         @(negedge clk);
         if (led === 1'b1) lit++;
      end
      checks++;
      if (lit !== exp_cnt.pop_front()) begin
         errors++;
         $display("FAIL pwm_0 lit clocks got %0d expected 0", lit);
      end
   endtask
`endif

   initial begin
      test_reset();
`ifdef LED_PWM_DIM_EN
      test_pwm();
`else
      test_code3();
      test_solid();
      test_deferred_load();
      test_load_at_frame_end();
      test_reset_mid_frame();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
